// File: rtl/gst_dma_snd_pkg.sv
// gst_dma_snd_pkg -- shared definitions for the STE DMA-sound fetch sequencer.
//
// Contents:
//   ADDR_W        width of the byte address counter (24 bits, bit0 always 0)
//   state_t       FSM state encoding plus the four state constants
//   REG_*         word offsets A[6:1] of the sound register page ($FF8900)
package gst_dma_snd_pkg;

   localparam int ADDR_W = 24;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;
   localparam logic [1:0] ST_ADV  = 2'd3;

   localparam logic [5:0] REG_CTRL    = 6'h00;
   localparam logic [5:0] REG_START_H = 6'h01;
   localparam logic [5:0] REG_START_M = 6'h02;
   localparam logic [5:0] REG_START_L = 6'h03;
   localparam logic [5:0] REG_CNT_H   = 6'h04;
   localparam logic [5:0] REG_CNT_M   = 6'h05;
   localparam logic [5:0] REG_CNT_L   = 6'h06;
   localparam logic [5:0] REG_END_H   = 6'h07;
   localparam logic [5:0] REG_END_M   = 6'h08;
   localparam logic [5:0] REG_END_L   = 6'h09;

endpackage

// File: rtl/gst_dma_snd_regs.sv
// gst_dma_snd_regs -- CPU register page of the DMA-sound sequencer.
//
// Holds PLAY/LOOP, the frame start and frame end registers and the read mux.
// Optional build macro DMASND_FRAME_LATCH_EN: start/end writes land in
// shadow registers and the end value used by the fetch sequencer only
// changes when the sequencer asks for it (frame start or loop reload).
//
// Ports:
//   clk32, rst            clock, asynchronous active-high reset
//   cs, a, din, rw        CPU bus (byte registers on din[7:0])
//   dout                  read data, 0 unless cs && rw
//   counter               live frame counter, for readout
//   clear_play            sequencer request to drop PLAY (CPU write wins)
//   latch_act             sequencer frame boundary: copy end into active end
//   play, loop            control bits
//   ctrl_wr               CPU write to the control register this cycle
//   ld_start, ld_end      values a new frame is started from
//   act_end               end address the running frame compares against
module gst_dma_snd_regs
   import gst_dma_snd_pkg::*;
(
   input  logic              clk32,
   input  logic              rst,
   input  logic              cs,
   input  logic [5:0]        a,
   input  logic [15:0]       din,
   input  logic              rw,
   output logic [15:0]       dout,
   input  logic [ADDR_W-1:0] counter,
   input  logic              clear_play,
   input  logic              latch_act,
   output logic              play,
   output logic              loop,
   output logic              ctrl_wr,
   output logic [ADDR_W-1:0] ld_start,
   output logic [ADDR_W-1:0] ld_end,
   output logic [ADDR_W-1:0] act_end
);

   logic              play_q, play_d;
   logic              loop_q, loop_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              wr;
   logic [7:0]        din_hi_unused;

   assign din_hi_unused = din[15:8];
   assign wr            = cs && !rw;
   assign ctrl_wr       = wr && (a == REG_CTRL);

   always_comb begin
      play_d  = play_q;
      loop_d  = loop_q;
      start_d = start_q;
      end_d   = end_q;
      if (clear_play) play_d = 1'b0;
      // A CPU control write in the same cycle overrides the sequencer.
      if (ctrl_wr) begin
         play_d = din[0];
         loop_d = din[1];
      end
      if (wr) begin
         case (a)
            REG_START_H: start_d[23:16] = din[7:0];
            REG_START_M: start_d[15:8]  = din[7:0];
            REG_START_L: start_d[7:0]   = {din[7:1], 1'b0};
            REG_END_H:   end_d[23:16]   = din[7:0];
            REG_END_M:   end_d[15:8]    = din[7:0];
            REG_END_L:   end_d[7:0]     = {din[7:1], 1'b0};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
         play_q  <= 1'b0;
         loop_q  <= 1'b0;
         start_q <= '0;
         end_q   <= '0;
      end else begin
         play_q  <= play_d;
         loop_q  <= loop_d;
         start_q <= start_d;
         end_q   <= end_d;
      end
   end

   // Every counter load coincides with a latch point, so the start value is
   // always consumed straight from the register; no active copy is needed.
   assign ld_start = start_q;
   assign ld_end   = end_q;

`ifdef DMASND_FRAME_LATCH_EN
   logic [ADDR_W-1:0] act_end_q, act_end_d;

   always_comb begin
      act_end_d = act_end_q;
      if (latch_act) act_end_d = end_q;
   end

   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) act_end_q <= '0;
      else     act_end_q <= act_end_d;
   end

   assign act_end = act_end_q;
`else
   logic latch_act_unused;
   assign latch_act_unused = latch_act;
   assign act_end          = end_q;
`endif

   always_comb begin
      dout = '0;
      if (cs && rw) begin
         case (a)
            REG_CTRL:    dout[1:0] = {loop_q, play_q};
            REG_START_H: dout[7:0] = start_q[23:16];
            REG_START_M: dout[7:0] = start_q[15:8];
            REG_START_L: dout[7:0] = start_q[7:0];
            REG_CNT_H:   dout[7:0] = counter[23:16];
            REG_CNT_M:   dout[7:0] = counter[15:8];
            REG_CNT_L:   dout[7:0] = counter[7:0];
            REG_END_H:   dout[7:0] = end_q[23:16];
            REG_END_M:   dout[7:0] = end_q[15:8];
            REG_END_L:   dout[7:0] = end_q[7:0];
            default: ;
         endcase
      end
   end

   assign play = play_q;
   assign loop = loop_q;

endmodule

// File: rtl/gst_dma_snd.sv
// gst_dma_snd -- STE DMA-sound fetch sequencer.
//
// Walks a frame counter from frame start to frame end, strobing SLOAD_N low
// for LOAD_LEN cycles per word while the audio FIFO requests data (SREQ) and
// a sound slot (SND_SLOT) is granted. Up to FETCH_PER_SLOT words per slot.
// SINT pulses at end of frame. Optional macro DMASND_FRAME_LATCH_EN selects
// shadowed start/end registers (see gst_dma_snd_regs).
//
// Ports:
//   clk32, rst        clock, asynchronous active-high reset
//   CS, A, DIN, RW    CPU register access; DOUT read data
//   SREQ              FIFO not full
//   SND_SLOT          one-cycle fetch window pulse
//   SLOAD_N           active-low fetch strobe
//   SADDR             word address of the current fetch
//   SACTIVE           PLAY level
//   SINT              one-cycle end-of-frame pulse
//   dbg_state         current FSM state
module gst_dma_snd
   import gst_dma_snd_pkg::*;
#(
   parameter int LOAD_LEN       = 4,
   parameter int FETCH_PER_SLOT = 2
) (
   input  logic        clk32,
   input  logic        rst,
   input  logic        CS,
   input  logic [5:0]  A,
   input  logic [15:0] DIN,
   input  logic        RW,
   output logic [15:0] DOUT,
   input  logic        SREQ,
   input  logic        SND_SLOT,
   output logic        SLOAD_N,
   output logic [22:0] SADDR,
   output logic        SACTIVE,
   output logic        SINT,
   output state_t      dbg_state
);

   localparam logic [3:0] LOAD_LAST = 4'(LOAD_LEN - 1);
   localparam logic [2:0] FETCH_LIM = 3'(FETCH_PER_SLOT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] counter_q, counter_d;
   logic [2:0]        slot_cnt_q, slot_cnt_d;
   logic [3:0]        load_cnt_q, load_cnt_d;
   logic              sint_q, sint_d;

   logic              play, loop, ctrl_wr;
   logic              clear_play, latch_act, sint_now, abort;
   logic [ADDR_W-1:0] ld_start, ld_end, act_end, cnt_inc;
   logic [2:0]        slot_inc;

   gst_dma_snd_regs u_regs (
      .clk32      (clk32),
      .rst        (rst),
      .cs         (CS),
      .a          (A),
      .din        (DIN),
      .rw         (RW),
      .dout       (DOUT),
      .counter    (counter_q),
      .clear_play (clear_play),
      .latch_act  (latch_act),
      .play       (play),
      .loop       (loop),
      .ctrl_wr    (ctrl_wr),
      .ld_start   (ld_start),
      .ld_end     (ld_end),
      .act_end    (act_end)
   );

   // Clearing PLAY from the CPU aborts whatever the sequencer is doing at
   // the very edge that captures the write.
   assign abort    = ctrl_wr && !DIN[0];
   assign cnt_inc  = counter_q + 24'd2;
   assign slot_inc = slot_cnt_q + 3'd1;

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      slot_cnt_d = slot_cnt_q;
      load_cnt_d = load_cnt_q;
      sint_d     = 1'b0;
      sint_now   = 1'b0;
      clear_play = 1'b0;
      latch_act  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (play) begin
               counter_d = ld_start;
               latch_act = 1'b1;
               state_d   = ST_WAIT;
               // Empty frame: report it, and without LOOP give up at once.
               if (ld_start == ld_end) begin
                  sint_d = 1'b1;
                  if (!loop) begin
                     clear_play = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end
            end
         end
         ST_WAIT: begin
            // A slot without SREQ is simply lost; nothing is remembered.
            if (SND_SLOT && SREQ && (counter_q != act_end)) begin
               state_d    = ST_LOAD;
               slot_cnt_d = 3'd0;
               load_cnt_d = 4'd0;
            end
         end
         ST_LOAD: begin
            if (load_cnt_q == LOAD_LAST) state_d = ST_ADV;
            else load_cnt_d = load_cnt_q + 4'd1;
         end
         ST_ADV: begin
            slot_cnt_d = slot_inc;
            if (cnt_inc == act_end) begin
               sint_now = 1'b1;
               if (loop) begin
                  counter_d = ld_start;
                  latch_act = 1'b1;
                  state_d   = ST_WAIT;
               end else begin
                  counter_d  = cnt_inc;
                  clear_play = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else begin
               counter_d = cnt_inc;
               if ((slot_inc < FETCH_LIM) && SREQ) begin
                  state_d    = ST_LOAD;
                  load_cnt_d = 4'd0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         counter_q  <= '0;
         slot_cnt_q <= '0;
         load_cnt_q <= '0;
         sint_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         slot_cnt_q <= slot_cnt_d;
         load_cnt_q <= load_cnt_d;
         sint_q     <= sint_d;
      end
   end

   // SLOAD_N decodes straight from the state flop so reset forces it high
   // without waiting for a clock edge.
   assign SLOAD_N   = (state_q != ST_LOAD);
   assign SADDR     = counter_q[23:1];
   assign SACTIVE   = play;
   assign SINT      = sint_q | sint_now;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gst_dma_snd.sv
// tb_gst_dma_snd -- directed self-checking bench for gst_dma_snd.
// Honours DMASND_FRAME_LATCH_EN for the frame-chaining step.
module tb_gst_dma_snd;
   import gst_dma_snd_pkg::*;

   logic        clk32 = 1'b0;
   logic        rst   = 1'b1;
   logic        CS    = 1'b0;
   logic [5:0]  A     = '0;
   logic [15:0] DIN   = '0;
   logic        RW    = 1'b1;
   logic        SREQ  = 1'b0;
   logic        SND_SLOT = 1'b0;
   logic [15:0] DOUT;
   logic        SLOAD_N;
   logic [22:0] SADDR;
   logic        SACTIVE;
   logic        SINT;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;

   // monitor state
   logic [22:0] fetch_addr_q[$];
   int          fetch_slot_q[$];
   int          len_q[$];
   logic [22:0] exp_q[$];
   int          slot_idx = 0;
   int          sint_cnt = 0;
   int          sint_at_fetch = -1;
   int          low_len = 0;
   logic        prev_sload = 1'b1;
   logic [15:0] rd;

   gst_dma_snd #(.LOAD_LEN(4), .FETCH_PER_SLOT(2)) dut (
      .clk32     (clk32),
      .rst       (rst),
      .CS        (CS),
      .A         (A),
      .DIN       (DIN),
      .RW        (RW),
      .DOUT      (DOUT),
      .SREQ      (SREQ),
      .SND_SLOT  (SND_SLOT),
      .SLOAD_N   (SLOAD_N),
      .SADDR     (SADDR),
      .SACTIVE   (SACTIVE),
      .SINT      (SINT),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk32 = ~clk32;

   // fetch / interrupt monitor, sampled on the falling edge
   always @(negedge clk32) begin
      if (SINT) begin
         sint_cnt++;
         sint_at_fetch = fetch_addr_q.size();
      end
      if (!SLOAD_N) begin
         if (prev_sload) begin
            fetch_addr_q.push_back(SADDR);
            fetch_slot_q.push_back(slot_idx);
            low_len = 0;
         end
         low_len++;
      end else if (!prev_sload) begin
         len_q.push_back(low_len);
      end
      prev_sload = SLOAD_N;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks (called at a falling edge, return at a falling edge)
   task automatic do_reset();
      rst = 1'b1;
      SND_SLOT = 1'b0;
      CS = 1'b0;
      RW = 1'b1;
      repeat (2) @(negedge clk32);
      rst = 1'b0;
      fetch_addr_q.delete();
      fetch_slot_q.delete();
      len_q.delete();
      slot_idx = 0;
      sint_cnt = 0;
      sint_at_fetch = -1;
   endtask

   task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
      CS = 1'b1; RW = 1'b0; A = a; DIN = d;
      @(negedge clk32);
      CS = 1'b0; RW = 1'b1;
   endtask

   task automatic cpu_read(input logic [5:0] a, output logic [15:0] d);
      CS = 1'b1; RW = 1'b1; A = a;
      #1 d = DOUT;
      CS = 1'b0;
   endtask

   task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
      cpu_write(REG_START_H, {8'h00, s[23:16]});
      cpu_write(REG_START_M, {8'h00, s[15:8]});
      cpu_write(REG_START_L, {8'h00, s[7:0]});
      cpu_write(REG_END_H,   {8'h00, e[23:16]});
      cpu_write(REG_END_M,   {8'h00, e[15:8]});
      cpu_write(REG_END_L,   {8'h00, e[7:0]});
   endtask

   task automatic run_slots(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap) @(negedge clk32);
         slot_idx++;
         SND_SLOT = 1'b1;
         @(negedge clk32);
         SND_SLOT = 1'b0;
      end
   endtask

   task automatic chk_counter(input string tag, input logic [23:0] exp);
      logic [15:0] h, m, l;
      cpu_read(REG_CNT_H, h);
      cpu_read(REG_CNT_M, m);
      cpu_read(REG_CNT_L, l);
      chk(tag, {8'h00, h[7:0], m[7:0], l[7:0]}, {8'h00, exp});
      chk({tag, "_hi_byte"}, {16'h0, h[15:8], m[15:8]}, 32'h0);
   endtask

   task automatic chk_fetches(input string tag);
      chk({tag, "_count"}, fetch_addr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_addr%0d", tag, i), {9'h0, fetch_addr_q[i]}, {9'h0, exp_q[i]});
   endtask

   initial begin
      // ---- reset state
      repeat (2) @(negedge clk32);
      chk("rst_sload_n", SLOAD_N, 1'b1);
      chk("rst_sactive", SACTIVE, 1'b0);
      chk("rst_sint", SINT, 1'b0);
      chk("rst_saddr", SADDR, 23'h0);
      chk("rst_state", dbg_state, ST_IDLE);
      do_reset();
      chk("rst_dout_idle", DOUT, 16'h0);
      cpu_read(REG_CTRL, rd);
      chk("rst_ctrl", rd, 16'h0);
      chk_counter("rst_counter", 24'h0);

      // ---- single frame, LOOP=0, two words per slot
      SREQ = 1'b1;
      set_frame(24'h010000, 24'h010008);
      cpu_write(REG_CTRL, 16'h0001);
      chk("t1_sactive_on", SACTIVE, 1'b1);
      run_slots(3, 63);
      repeat (20) @(negedge clk32);
      exp_q = '{23'h8000, 23'h8001, 23'h8002, 23'h8003};
      chk_fetches("t1");
      for (int i = 0; i < 4; i++) chk($sformatf("t1_len%0d", i), len_q[i], 4);
      chk("t1_slot0", fetch_slot_q[0], 1);
      chk("t1_slot1", fetch_slot_q[1], 1);
      chk("t1_slot2", fetch_slot_q[2], 2);
      chk("t1_slot3", fetch_slot_q[3], 2);
      chk("t1_sint_cnt", sint_cnt, 1);
      chk("t1_sint_at_4th", sint_at_fetch, 4);
      chk("t1_sactive_off", SACTIVE, 1'b0);
      chk("t1_state", dbg_state, ST_IDLE);
      chk_counter("t1_counter", 24'h010008);

      // ---- same frame with LOOP=1
      do_reset();
      SREQ = 1'b1;
      set_frame(24'h010000, 24'h010008);
      cpu_write(REG_CTRL, 16'h0003);
      run_slots(4, 63);
      repeat (20) @(negedge clk32);
      exp_q = '{23'h8000, 23'h8001, 23'h8002, 23'h8003,
                23'h8000, 23'h8001, 23'h8002, 23'h8003};
      chk_fetches("t2");
      chk("t2_slot4", fetch_slot_q[4], 3);
      chk("t2_slot7", fetch_slot_q[7], 4);
      chk("t2_sint_cnt", sint_cnt, 2);
      chk("t2_sactive", SACTIVE, 1'b1);
      chk("t2_state", dbg_state, ST_WAIT);
      chk_counter("t2_counter", 24'h010000);

      // ---- slots without SREQ are dropped
      do_reset();
      SREQ = 1'b0;
      set_frame(24'h010000, 24'h010008);
      cpu_write(REG_CTRL, 16'h0001);
      run_slots(3, 20);
      repeat (5) @(negedge clk32);
      chk("t3_no_fetch", fetch_addr_q.size(), 0);
      SREQ = 1'b1;
      repeat (5) @(negedge clk32);
      chk("t3_no_queued_slot", fetch_addr_q.size(), 0);
      run_slots(1, 20);
      repeat (20) @(negedge clk32);
      exp_q = '{23'h8000, 23'h8001};
      chk_fetches("t3");

      // ---- PLAY cleared during the second LOAD cycle
      do_reset();
      SREQ = 1'b1;
      set_frame(24'h010000, 24'h010008);
      cpu_write(REG_CTRL, 16'h0001);
      run_slots(1, 3);
      chk("t4_load_c1", SLOAD_N, 1'b0);
      @(negedge clk32);
      chk("t4_load_c2", SLOAD_N, 1'b0);
      cpu_write(REG_CTRL, 16'h0000);
      chk("t4_sload_n_high", SLOAD_N, 1'b1);
      chk("t4_state", dbg_state, ST_IDLE);
      chk("t4_sactive", SACTIVE, 1'b0);
      repeat (3) @(negedge clk32);
      chk("t4_low_len", len_q[0], 2);
      chk("t4_sint", sint_cnt, 0);
      chk_counter("t4_counter", 24'h010000);

      // ---- empty frame
      do_reset();
      SREQ = 1'b1;
      set_frame(24'h020000, 24'h020000);
      cpu_write(REG_CTRL, 16'h0001);
      repeat (5) @(negedge clk32);
      chk("t5_sint_cnt", sint_cnt, 1);
      cpu_read(REG_CTRL, rd);
      chk("t5_play_rb", rd, 16'h0000);
      run_slots(1, 5);
      repeat (10) @(negedge clk32);
      chk("t5_no_fetch", fetch_addr_q.size(), 0);

      // ---- end rewritten mid-frame of a looping frame
      do_reset();
      SREQ = 1'b1;
      set_frame(24'h030000, 24'h030010);
      cpu_write(REG_CTRL, 16'h0003);
      run_slots(2, 15);
      repeat (15) @(negedge clk32);
      chk_counter("t6_mid_counter", 24'h030008);
      cpu_write(REG_END_M, 16'h0001);
      cpu_write(REG_END_L, 16'h0000);
      cpu_read(REG_END_M, rd);
      chk("t6_end_mid_rb", rd, 16'h0001);
      run_slots(2, 15);
      repeat (15) @(negedge clk32);
      run_slots(1, 15);
      repeat (15) @(negedge clk32);
`ifdef DMASND_FRAME_LATCH_EN
      chk("t6_sint_cnt", sint_cnt, 1);
      chk("t6_fetch8", {9'h0, fetch_addr_q[8]}, 32'h18000);
      chk_counter("t6_counter", 24'h030004);
`else
      chk("t6_sint_cnt", sint_cnt, 0);
      chk("t6_fetch8", {9'h0, fetch_addr_q[8]}, 32'h18008);
      chk_counter("t6_counter", 24'h030014);
`endif

      // ---- reset asserted in the middle of a LOAD
      do_reset();
      SREQ = 1'b1;
      set_frame(24'h010000, 24'h010008);
      cpu_write(REG_CTRL, 16'h0001);
      run_slots(1, 3);
      chk("t7_in_load", SLOAD_N, 1'b0);
      rst = 1'b1;
      #1;
      chk("t7_async_sload_n", SLOAD_N, 1'b1);
      chk("t7_async_sactive", SACTIVE, 1'b0);
      @(negedge clk32);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gst_dma_snd.md
Name: gst_dma_snd

Overview:
STE DMA-sound fetch sequencer. It sits directly upstream of the shifter's audio FIFO. When the FIFO raises SREQ and the video timing offers a sound fetch slot, it walks a frame address counter from frame start to frame end and strobes SLOAD_N once per word. It also signals end-of-frame for Timer A / GPIP.

Parameters:
LOAD_LEN, 4, clk32 cycles SLOAD_N is held low per word fetch (range 2..15).
FETCH_PER_SLOT, 2, max words fetched per SND_SLOT pulse (range 1..4).

Ports:
clk32  in  1  system clock
rst  in  1  asynchronous reset, active-high
CS  in  1  register select (sound register page, base $FF8900)
A  in  6  word address A[6:1] within page
DIN  in  16  CPU write data
RW  in  1  1 = read, 0 = write
DOUT  out  16  register read data; 0 when not (CS && RW)
SREQ  in  1  FIFO not full, from shifter
SND_SLOT  in  1  one-cycle pulse marking a granted sound fetch window
SLOAD_N  out  1  fetch strobe to RAM/shifter, active low
SADDR  out  23  word address [23:1] of current fetch
SACTIVE  out  1  play-in-progress level
SINT  out  1  one-cycle end-of-frame pulse

Behaviour:
- Register map, A[6:1]; byte registers sit in DIN/DOUT[7:0], upper byte reads 0:
  - $00 control: bit0 PLAY, bit1 LOOP.
  - $01/$02/$03 start hi/mid/lo; lo bit0 forced 0.
  - $04/$05/$06 counter hi/mid/lo, read-only.
  - $07/$08/$09 end hi/mid/lo; lo bit0 forced 0.
- Reset: PLAY=LOOP=0, start=end=counter=0, SLOAD_N=1, SACTIVE=0, SINT=0, SADDR=0, FSM=IDLE.
- SACTIVE = PLAY. SADDR = counter[23:1].
- FSM states:
  - IDLE: PLAY 0->1 loads counter from active start, active end from end register -> WAIT. If start == end at that moment: pulse SINT next cycle; if LOOP=0 clear PLAY and stay IDLE, else stay WAIT without fetching.
  - WAIT: on SND_SLOT && SREQ && counter != end -> LOAD, slot word count = 0. SND_SLOT without SREQ is ignored and is not queued.
  - LOAD: SLOAD_N=0 for exactly LOAD_LEN cycles, SADDR stable throughout -> ADV.
  - ADV (1 cycle, SLOAD_N=1): counter += 2 (24-bit, wraps $FFFFFE->$000000), slot word count += 1.
    - Next counter == end: SINT pulses in this same cycle. LOOP=1: reload counter from start -> WAIT. LOOP=0: clear PLAY -> IDLE.
    - Else if slot word count < FETCH_PER_SLOT and SREQ still high -> LOAD.
    - Else -> WAIT.
- CPU write PLAY=0 in any state: abort at the next clk32 edge. SLOAD_N returns high immediately, the partial word is not counted, -> IDLE, no SINT.
- Write to $00 in the same cycle as ADV end-of-frame: the CPU write wins for PLAY/LOOP. SINT still pulses.
- Counter readout is live; no snapshot latch.
- Reset asserted mid-LOAD: SLOAD_N goes to 1 asynchronously.

Optional Feature:
DMASND_FRAME_LATCH_EN.
- Defined: start/end writes go to shadow registers. Active start/end update only on IDLE->WAIT or on a LOOP reload (STE-accurate seamless frame chaining). Reads of $01-$03/$07-$09 return the shadows.
- Undefined: a single register set. Writes take effect immediately, including the end comparison in the next ADV.

Decomposition:
- Package gst_dma_snd_pkg:
  - state enum (IDLE, WAIT, LOAD, ADV)
  - register offset localparams (REG_CTRL, REG_START_H/M/L, REG_CNT_H/M/L, REG_END_H/M/L)
  - ADDR_W = 24
- One natural sub-module: gst_dma_snd_regs (CPU decode, start/end/control storage, shadow logic under the macro), leaving the FSM and counter in the top.

Test Plan:
- Start $010000, end $010008, LOOP=0, PLAY=1; SREQ=1, SND_SLOT pulses every 64 cycles.
  - Required: 4 fetches at SADDR $8000..$8003, two per slot, each SLOAD_N low for 4 cycles.
  - SINT pulses once on the 4th ADV; SACTIVE then drops and the counter reads $010008.
- Same frame with LOOP=1.
  - Required: after the 4th word the counter returns to $010000 and SINT pulses each frame.
  - Fetch continues with no extra slot lost.
- SREQ=0 while SND_SLOT pulses 3 times.
  - Required: no SLOAD_N activity.
  - After SREQ rises, the next slot fetches word $010000.
- PLAY cleared on cycle 2 of a LOAD.
  - Required: SLOAD_N high next cycle, counter unchanged, no SINT, FSM IDLE.
- Start = end = $020000, PLAY=1, LOOP=0.
  - Required: one SINT pulse, PLAY reads back 0, zero fetches.
- With DMASND_FRAME_LATCH_EN defined: write end=$030100 mid-frame of a $030000..$030010 loop.
  - Required: the current frame still stops at $030010; the next loop runs to $030100.
  - Without the macro: the current frame continues to $030100.
